// File: rtl/rev_shift_right_pipe.sv
// rev_shift_right_pipe
//   Three-stage pipelined 8-bit right shifter/rotator built from reversible
//   2:1 mux cells (P=A, Q=~A&B|A&C; only Q is used). Stage k shifts by 2^k
//   when shift bit k is set, with a register after each stage and
//   valid/ready handshakes on both sides.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   X/Y/mode valid this cycle
//   in_ready   block accepts an input this cycle
//   X          operand
//   Y          shift amount
//   mode       00 logical, 01 arithmetic, 10 rotate, 11 logical (reserved)
//   out_valid  Z holds a result
//   out_ready  downstream consumes Z this cycle
//   Z          result
module rev_shift_right_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [SHW-1:0]   Y,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z
);

  typedef enum logic [1:0] {
    MODE_LSR = 2'b00,
    MODE_ASR = 2'b01,
    MODE_ROR = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  // Reversible cell, Q output only: control a selects c (shifted/fill) over b.
  function automatic logic rev_cell_q(input logic a, input logic b, input logic c);
    return (~a & b) | (a & c);
  endfunction

  // One mux stage: conditional right shift by amt with mode-dependent fill.
  // The source index wraps modulo WIDTH, which is exactly the rotate source;
  // for logical/arithmetic the wrapped positions are replaced by the fill.
  function automatic logic [WIDTH-1:0] stage_shift(
    input logic [WIDTH-1:0] d,
    input logic             ctl,
    input logic [1:0]       m,
    input logic             f,
    input int unsigned      amt
  );
    logic [WIDTH-1:0] r;
    logic [SHW-1:0]   src;
    logic             c;
    r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      src = SHW'(i + amt);
      if (i + amt < WIDTH) begin
        c = d[src];
      end else if (m == MODE_ROR) begin
        c = d[src];
      end else if (m == MODE_ASR) begin
        c = f;
      end else begin
        c = 1'b0;
      end
      r[SHW'(i)] = rev_cell_q(ctl, d[SHW'(i)], c);
    end
    return r;
  endfunction

  // Stage 1
  logic             v1_q, v1_d;
  logic [WIDTH-1:0] d1_q, d1_d;
  logic [1:0]       y1_q, y1_d;
  logic [1:0]       m1_q, m1_d;
  logic             f1_q, f1_d;
  // Stage 2
  logic             v2_q, v2_d;
  logic [WIDTH-1:0] d2_q, d2_d;
  logic             y2_q, y2_d;
  logic [1:0]       m2_q, m2_d;
  logic             f2_q, f2_d;
  // Stage 3 (only the result is needed beyond this point)
  logic             v3_q, v3_d;
  logic [WIDTH-1:0] d3_q, d3_d;

  logic adv1, adv2, adv3;
  logic in_fire;
  logic fill_in;

  // Ready ripples backwards: a stage may load whenever it is empty or the
  // stage after it is moving, so a full pipe still accepts when out_ready=1.
  always_comb begin
    adv3     = ~v3_q | out_ready;
    adv2     = ~v2_q | adv3;
    adv1     = ~v1_q | adv2;
    in_ready = adv1 & rst_n;
    in_fire  = in_valid & in_ready;
    fill_in  = (mode == MODE_ASR) ? X[WIDTH-1] : 1'b0;
  end

  always_comb begin
    v1_d = v1_q;
    d1_d = d1_q;
    y1_d = y1_q;
    m1_d = m1_q;
    f1_d = f1_q;
    v2_d = v2_q;
    d2_d = d2_q;
    y2_d = y2_q;
    m2_d = m2_q;
    f2_d = f2_q;
    v3_d = v3_q;
    d3_d = d3_q;

    if (adv1) begin
      v1_d = in_fire;
      d1_d = stage_shift(X, Y[0], mode, fill_in, 1);
      y1_d = Y[2:1];
      m1_d = mode;
      f1_d = fill_in;
    end

    if (adv2) begin
      v2_d = v1_q;
      d2_d = stage_shift(d1_q, y1_q[0], m1_q, f1_q, 2);
      y2_d = y1_q[1];
      m2_d = m1_q;
      f2_d = f1_q;
    end

    if (adv3) begin
      v3_d = v2_q;
      d3_d = stage_shift(d2_q, y2_q, m2_q, f2_q, 4);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      d1_q <= '0;
      y1_q <= '0;
      m1_q <= '0;
      f1_q <= 1'b0;
      v2_q <= 1'b0;
      d2_q <= '0;
      y2_q <= 1'b0;
      m2_q <= '0;
      f2_q <= 1'b0;
      v3_q <= 1'b0;
      d3_q <= '0;
    end else begin
      v1_q <= v1_d;
      d1_q <= d1_d;
      y1_q <= y1_d;
      m1_q <= m1_d;
      f1_q <= f1_d;
      v2_q <= v2_d;
      d2_q <= d2_d;
      y2_q <= y2_d;
      m2_q <= m2_d;
      f2_q <= f2_d;
      v3_q <= v3_d;
      d3_q <= d3_d;
    end
  end

  assign out_valid = v3_q;
  assign Z         = d3_q;

endmodule

// File: tb/tb_rev_shift_right_pipe.sv
module tb_rev_shift_right_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] X;
  logic [2:0] Y;
  logic [1:0] mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] Z;

  rev_shift_right_pipe #(.WIDTH(8), .SHW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] z;
    int         acc;
    bit         lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   ov_count = 0;

  function automatic logic [7:0] ref_model(input logic [7:0] x, input logic [2:0] y,
                                           input logic [1:0] m);
    logic signed [7:0] sx;
    logic [15:0]       w;
    sx = x;
    w  = {x, x} >> y;
    case (m)
      2'b01:   return sx >>> y;
      2'b10:   return w[7:0];
      default: return x >> y;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, observe handshakes, update scoreboard,
  // then cross the rising edge and return at the next negedge.
  task automatic step(input logic iv, input logic [7:0] x, input logic [2:0] y,
                      input logic [1:0] m, input logic ordy, input logic [7:0] exp,
                      input bit lat, output logic acc);
    exp_t e;
    in_valid  = iv;
    X         = x;
    Y         = y;
    mode      = m;
    out_ready = ordy;
    #1;
    acc = iv && in_ready;
    if (out_valid && ordy) begin
      ov_count++;
      chk("sb_underflow", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("Z", {24'd0, Z}, {24'd0, e.z});
        if (e.lat) chk("latency", cyc - e.acc, 32'd3);
      end
    end
    if (acc) begin
      e.z   = exp;
      e.acc = cyc;
      e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input string tag, input logic [7:0] x, input logic [2:0] y,
                      input logic [1:0] m, input logic [7:0] exp);
    logic acc;
    step(1'b1, x, y, m, 1'b1, exp, 1'b1, acc);
    chk(tag, {31'd0, acc}, 32'd1);
  endtask

  task automatic drain();
    logic acc;
    for (int n = 0; n < 20 && sb.size() > 0; n++)
      step(1'b0, 8'h00, 3'd0, 2'd0, 1'b1, 8'h00, 1'b0, acc);
    chk("drain_empty", sb.size(), 32'd0);
  endtask

  logic [7:0] bp_x [5];
  logic [7:0] bp_z [5];

  initial begin
    logic       acc;
    int         idx;
    logic [7:0] rx;
    logic [2:0] ry;
    logic [1:0] rm;

    bp_x = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    bp_z = '{8'h08, 8'h10, 8'h18, 8'h20, 8'h28};

    // Reset
    rst_n = 1'b0; in_valid = 1'b0; X = '0; Y = '0; mode = '0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_Z", {24'd0, Z}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // Mode sweep, back to back
    send("sweep_acc00", 8'b10110010, 3'd3, 2'b00, 8'b00010110);
    send("sweep_acc01", 8'b10110010, 3'd3, 2'b01, 8'b11110110);
    send("sweep_acc10", 8'b10110010, 3'd3, 2'b10, 8'b01010110);
    drain();

    // Boundaries
    for (int m = 0; m < 4; m++) send("y0_acc", 8'hA5, 3'd0, 2'(m), 8'hA5);
    send("y7_lsr_acc", 8'hFF, 3'd7, 2'b00, 8'h01);
    send("y7_asr_acc", 8'h80, 3'd7, 2'b01, 8'hFF);
    send("y7_ror_acc", 8'h01, 3'd7, 2'b10, 8'h02);
    send("m11_acc",    8'h80, 3'd1, 2'b11, 8'h40);
    drain();

    // Backpressure: out_ready low for 6 cycles
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      step(idx < 5, bp_x[idx < 5 ? idx : 0], 3'd1, 2'b00, 1'b0,
           bp_z[idx < 5 ? idx : 0], 1'b0, acc);
      if (acc) idx++;
      if (k >= 2) begin
        chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_hold_Z", {24'd0, Z}, 32'h08);
      end
    end
    chk("bp_accepts", idx, 32'd3);
    #1;
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 20 && (idx < 5 || sb.size() > 0); k++) begin
      step(idx < 5, bp_x[idx < 5 ? idx : 0], 3'd1, 2'b00, 1'b1,
           bp_z[idx < 5 ? idx : 0], 1'b0, acc);
      if (acc) idx++;
    end
    chk("bp_all_sent", idx, 32'd5);
    chk("bp_all_recv", sb.size(), 32'd0);

    // Throughput: 16 random back-to-back operations
    ov_count = 0;
    for (int i = 0; i < 16; i++) begin
      rx = 8'($urandom);
      ry = 3'($urandom_range(7, 0));
      rm = 2'($urandom_range(3, 0));
      step(1'b1, rx, ry, rm, 1'b1, ref_model(rx, ry, rm), 1'b1, acc);
      chk("tp_in_ready", {31'd0, acc}, 32'd1);
    end
    drain();
    chk("tp_out_count", ov_count, 32'd16);

    // Reset with two items in flight
    send("rm_acc_a", 8'h11, 3'd1, 2'b00, 8'h08);
    send("rm_acc_b", 8'h22, 3'd1, 2'b00, 8'h11);
    rst_n = 1'b0;
    step(1'b1, 8'h33, 3'd1, 2'b00, 1'b1, 8'h19, 1'b0, acc);
    chk("rm_no_accept", {31'd0, acc}, 32'd0);
    sb.delete();
    rst_n = 1'b1;
    chk("rm_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rm_Z", {24'd0, Z}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 8'h00, 3'd0, 2'd0, 1'b1, 8'h00, 1'b0, acc);
      chk("rm_no_stale", {31'd0, out_valid}, 32'd0);
    end
    send("rm_new_acc", 8'hC3, 3'd2, 2'b10, 8'hF0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
